// File: rtl/aes_ctr_if.sv
// Stream, configuration and cipher-core signals of aes_ctr_ctrl.
// The slave modport is the controller's view. The master modport is the environment's view.
interface aes_ctr_if #(
  parameter int BLOCK_W = 128,
  parameter int CTR_W   = 32
);
  logic                       cfg_load;
  logic                       cfg_abort;
  logic                       cfg_mode;
  logic [BLOCK_W-1:0]         cfg_key;
  logic [BLOCK_W-CTR_W-1:0]   cfg_nonce;
  logic [CTR_W-1:0]           cfg_ctr0;
  logic                       in_valid;
  logic                       in_ready;
  logic [BLOCK_W-1:0]         in_data;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [BLOCK_W-1:0]         out_data;
  logic                       out_last;
  logic                       core_start;
  logic [BLOCK_W-1:0]         core_key;
  logic [BLOCK_W-1:0]         core_block;
  logic                       core_done;
  logic [BLOCK_W-1:0]         core_result;
  logic                       busy;
  logic                       ctr_wrap;

  modport slave (
    input  cfg_load, cfg_abort, cfg_mode, cfg_key, cfg_nonce, cfg_ctr0,
           in_valid, in_data, in_last, out_ready, core_done, core_result,
    output in_ready, out_valid, out_data, out_last, core_start, core_key,
           core_block, busy, ctr_wrap
  );

  modport master (
    output cfg_load, cfg_abort, cfg_mode, cfg_key, cfg_nonce, cfg_ctr0,
           in_valid, in_data, in_last, out_ready, core_done, core_result,
    input  in_ready, out_valid, out_data, out_last, core_start, core_key,
           core_block, busy, ctr_wrap
  );
endinterface

// File: rtl/aes_ctr_ctrl.sv
// ECB/CTR mode controller for an external block-cipher core.
// The controller handles one block at a time and has a managed counter with sticky wrap detection.
module aes_ctr_ctrl #(
  parameter int BLOCK_W = 128,
  parameter int CTR_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  aes_ctr_if.slave    bus
);
  localparam int NONCE_W = BLOCK_W - CTR_W;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_IN   = 3'd1;
  localparam logic [2:0] S_CORE_REQ  = 3'd2;
  localparam logic [2:0] S_CORE_WAIT = 3'd3;
  localparam logic [2:0] S_OUT_HOLD  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic               mode_q, mode_d;
  logic               wrap_q, wrap_d;
  logic [BLOCK_W-1:0] pt_q, pt_d;
  logic               last_q, last_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] out_q, out_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    ctr_d   = ctr_q;
    mode_d  = mode_q;
    wrap_d  = wrap_q;
    pt_d    = pt_q;
    last_d  = last_q;
    blk_d   = blk_q;
    out_d   = out_q;
    // Abort freezes every data register, so a done or load in the same cycle is dropped.
    if (bus.cfg_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.cfg_load) begin
          key_d   = bus.cfg_key;
          nonce_d = bus.cfg_nonce;
          ctr_d   = bus.cfg_ctr0;
          mode_d  = bus.cfg_mode;
          wrap_d  = 1'b0;
          state_d = S_WAIT_IN;
        end
        S_WAIT_IN: if (bus.in_valid) begin
          pt_d    = bus.in_data;
          last_d  = bus.in_last;
          // Load the core block here so that it is already stable in the start cycle.
          blk_d   = mode_q ? {nonce_q, ctr_q} : bus.in_data;
          state_d = S_CORE_REQ;
        end
        S_CORE_REQ: state_d = S_CORE_WAIT;
        S_CORE_WAIT: if (bus.core_done) begin
          out_d = mode_q ? (bus.core_result ^ pt_q) : bus.core_result;
          if (mode_q) begin
            ctr_d = ctr_q + 1'b1;
            if (&ctr_q) wrap_d = 1'b1;
          end
          state_d = S_OUT_HOLD;
        end
        S_OUT_HOLD: if (bus.out_ready) state_d = last_q ? S_IDLE : S_WAIT_IN;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      nonce_q <= '0;
      ctr_q   <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
      pt_q    <= '0;
      last_q  <= 1'b0;
      blk_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ctr_q   <= ctr_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      pt_q    <= pt_d;
      last_q  <= last_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.in_ready   = (state_q == S_WAIT_IN);
  assign bus.out_valid  = (state_q == S_OUT_HOLD) && !bus.cfg_abort;
  assign bus.core_start = (state_q == S_CORE_REQ) && !bus.cfg_abort;
  assign bus.out_data   = out_q;
  assign bus.out_last   = last_q;
  assign bus.core_key   = key_q;
  assign bus.core_block = blk_q;
  assign bus.busy       = busy_q;
  assign bus.ctr_wrap   = wrap_q;
endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Directed-vector bench for aes_ctr_ctrl, with a fixed-latency model cipher core.
module tb_aes_ctr_ctrl;
  localparam int BW = 128;
  localparam int CW = 32;
  localparam int L  = 3;
  localparam logic [127:0] KEY     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [95:0]  NW      = 96'hf0e1d2c3b4a5968778695a4b;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_ctr_if #(.BLOCK_W(BW), .CTR_W(CW)) bus ();
  aes_ctr_ctrl #(.BLOCK_W(BW), .CTR_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Model core: the result is the fixed FIPS ciphertext or block^key, and done comes L cycles after start.
  logic         core_en = 1'b1, use_fips = 1'b0, man_done = 1'b0, mdl_done = 1'b0;
  logic [127:0] mdl_res = '0;
  int           cnt = 0, start_cnt = 0;
  logic         mon_en = 1'b0, ov_seen = 1'b0;

  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (bus.core_start && core_en) begin
      cnt     <= L - 1;
      mdl_res <= use_fips ? FIPS_CT : (bus.core_block ^ bus.core_key);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) mdl_done <= 1'b1;
    end
  end
  always @(posedge clk) if (bus.core_start) start_cnt <= start_cnt + 1;
  always @(posedge clk) if (mon_en && bus.out_valid) ov_seen <= 1'b1;

  assign bus.core_done   = mdl_done | man_done;
  assign bus.core_result = mdl_res;

  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic         newmsg;
    logic         mode;
    logic         fips;
    logic [95:0]  nonce;
    logic [31:0]  ctr0;
    logic [127:0] pt;
    logic         last;
    logic [127:0] exp_blk;
    logic [127:0] exp_out;
    logic         exp_wrap;
  } vec_t;

  task automatic cfg(input logic mode, input logic [95:0] nonce, input logic [31:0] ctr0);
    @(negedge clk);
    bus.cfg_mode = mode; bus.cfg_key = KEY; bus.cfg_nonce = nonce; bus.cfg_ctr0 = ctr0;
    bus.cfg_load = 1'b1;
    @(negedge clk);
    bus.cfg_load = 1'b0;
  endtask

  task automatic wait_in_ready(input string nm);
    int n = 0;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_in_ready"}, bus.in_ready, 1);
  endtask

  task automatic send_block(input string nm, input logic [127:0] pt, input logic last,
                            input logic [127:0] exp_blk, input logic [127:0] exp_out, input int hold);
    int n;
    logic stable;
    int s;
    wait_in_ready(nm);
    bus.in_data = pt; bus.in_last = last; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({nm, "_start"}, bus.core_start, 1);
    chk({nm, "_block"}, bus.core_block, exp_blk);
    chk({nm, "_key"}, bus.core_key, KEY);
    n = 1;
    while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, n, L + 2);
    chk({nm, "_out_data"}, bus.out_data, exp_out);
    chk({nm, "_out_last"}, bus.out_last, last);
    if (hold > 0) begin
      stable = 1'b1;
      s = start_cnt;
      repeat (hold) begin
        @(negedge clk);
        if (!bus.out_valid || bus.out_data !== exp_out || bus.in_ready) stable = 1'b0;
      end
      chk({nm, "_bp_stable"}, stable, 1);
      chk({nm, "_bp_no_start"}, start_cnt, s);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  vec_t v[7];

  initial begin
    bus.cfg_load = 0; bus.cfg_abort = 0; bus.cfg_mode = 0; bus.cfg_key = '0;
    bus.cfg_nonce = '0; bus.cfg_ctr0 = '0; bus.in_valid = 0; bus.in_data = '0;
    bus.in_last = 0; bus.out_ready = 0;

    v[0] = '{1, 0, 1, 96'h0, 32'h0, FIPS_PT, 1, FIPS_PT, FIPS_CT, 0};
    v[1] = '{1, 1, 0, 96'h0, 32'h5, 128'h00112233445566778899aabbccddeeff, 0, 128'h5,
             128'h00112233445566778899aabbccddeeff ^ 128'h5 ^ KEY, 0};
    v[2] = '{0, 1, 0, 96'h0, 32'h5, 128'h0f0e0d0c0b0a09080706050403020100, 0, 128'h6,
             128'h0f0e0d0c0b0a09080706050403020100 ^ 128'h6 ^ KEY, 0};
    v[3] = '{0, 1, 0, 96'h0, 32'h5, 128'hdeadbeefcafef00d0123456789abcdef, 1, 128'h7,
             128'hdeadbeefcafef00d0123456789abcdef ^ 128'h7 ^ KEY, 0};
    v[4] = '{1, 1, 0, NW, 32'hffffffff, 128'h11111111222222223333333344444444, 0,
             {NW, 32'hffffffff}, 128'h11111111222222223333333344444444 ^ {NW, 32'hffffffff} ^ KEY, 1};
    v[5] = '{0, 1, 0, NW, 32'hffffffff, 128'h55555555666666667777777788888888, 1,
             {NW, 32'h00000000}, 128'h55555555666666667777777788888888 ^ {NW, 32'h00000000} ^ KEY, 1};
    v[6] = '{1, 0, 0, NW, 32'h12345678, 128'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5a, 1,
             128'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5a, 128'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5a ^ KEY, 0};

    #1 rst = 1'b1;
    #1;
    chk("reset_ctl", {bus.in_ready, bus.out_valid, bus.core_start, bus.busy, bus.ctr_wrap, bus.out_last}, 0);
    chk("reset_data", bus.out_data | bus.core_key | bus.core_block, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_load", {bus.busy, bus.in_ready}, 0);

    for (int i = 0; i < 7; i++) begin
      if (v[i].newmsg) cfg(v[i].mode, v[i].nonce, v[i].ctr0);
      use_fips = v[i].fips;
      send_block($sformatf("vec%0d", i), v[i].pt, v[i].last, v[i].exp_blk, v[i].exp_out, 0);
      chk($sformatf("vec%0d_wrap", i), bus.ctr_wrap, v[i].exp_wrap);
      if (v[i].last) begin
        repeat (3) @(negedge clk);
        chk($sformatf("vec%0d_idle", i), {bus.busy, bus.in_ready, bus.ctr_wrap}, {2'b00, v[i].exp_wrap});
      end
    end
    use_fips = 1'b0;

    // Backpressure: out_ready is held low for 10 cycles.
    cfg(1'b0, 96'h0, 32'h0);
    send_block("bp", 128'h0123456789abcdeffedcba9876543210, 1'b1,
               128'h0123456789abcdeffedcba9876543210, 128'h0123456789abcdeffedcba9876543210 ^ KEY, 10);
    @(negedge clk);
    chk("bp_idle", bus.busy, 0);

    // Abort in CORE_WAIT, followed by a stale done.
    cfg(1'b1, 96'h0, 32'h9);
    core_en = 1'b0; mon_en = 1'b1; ov_seen = 1'b0;
    wait_in_ready("abort");
    bus.in_data = 128'h77; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.cfg_abort = 1'b1;
    @(negedge clk);
    bus.cfg_abort = 1'b0;
    chk("abort_idle", {bus.busy, bus.in_ready}, 0);
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_out_valid", ov_seen, 0);
    chk("abort_stale_done", {bus.busy, bus.out_valid, bus.in_ready}, 0);
    mon_en = 1'b0; core_en = 1'b1;
    cfg(1'b1, 96'h0, 32'h9);
    send_block("post_abort", 128'h77, 1'b1, 128'h9, 128'h77 ^ 128'h9 ^ KEY, 0);

    // Async reset in OUT_HOLD, after a wrap has set ctr_wrap.
    cfg(1'b1, NW, 32'hffffffff);
    wait_in_ready("ar");
    bus.in_data = 128'hc0ffee; bus.in_last = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    begin
      int n = 0;
      while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    end
    chk("ar_pre_hold", {bus.out_valid, bus.ctr_wrap, bus.busy}, 3'b111);
    #2 rst = 1'b1;
    #1;
    chk("ar_ctl", {bus.in_ready, bus.out_valid, bus.core_start, bus.busy, bus.ctr_wrap, bus.out_last}, 0);
    chk("ar_out_data", bus.out_data, 0);
    chk("ar_core_key", bus.core_key, 0);
    chk("ar_core_block", bus.core_block, 0);
    @(negedge clk);
    bus.cfg_mode = 1'b1; bus.cfg_load = 1'b1;
    @(negedge clk);
    bus.cfg_load = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("ar_load_ignored", {bus.busy, bus.in_ready, bus.out_valid}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
